// File: rtl/mod_n_up_counter_pkg.sv
// Shared constants and elaboration helpers for the modulo-N up counter.
// The default modulus is the project timebase; other users pass their own N.
package mod_n_up_counter_pkg;

    localparam int unsigned DefaultN     = 10;
    localparam int unsigned DefaultWidth = 4;

    // True when 2 <= n <= 2**w and w >= 1; evaluated at elaboration only.
    function automatic bit params_legal(input int unsigned n, input int unsigned w);
        longint unsigned span;
        if (w < 1 || w > 32) begin
            return 1'b0;
        end
        span = longint'(1) << w;
        return (n >= 2) && (longint'(n) <= span);
    endfunction

endpackage

// File: rtl/mod_n_up_counter.sv
// Free-running synchronous modulo-N up counter with a terminal-count decode.
// Counts 0..N-1 and wraps; any out-of-range value is cleared on the next edge.
module mod_n_up_counter
    import mod_n_up_counter_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (!params_legal(N, WIDTH)) begin : g_bad_params
        $error("mod_n_up_counter: illegal parameters N=%0d WIDTH=%0d", N, WIDTH);
    end

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(N - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // '>=' folds the normal wrap and illegal-state recovery into one compare,
    // so wrap never depends on natural overflow of the adder.
    always_comb begin
        w_count_next = r_count + WIDTH'(1);
        if (r_count >= MaxCount) begin
            w_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == MaxCount);

endmodule

// File: tb/tb_mod_n_up_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares them against a N=10 and a N=16 counter instance.
module tb_mod_n_up_counter;

    typedef struct {
        bit         dut16;
        logic [3:0] exp_count;
        logic       exp_tc;
    } exp_t;

    logic       clk;
    logic       reset_a;
    logic       reset_b;
    logic [3:0] count_a;
    logic [3:0] count_b;
    logic       tc_a;
    logic       tc_b;

    exp_t q_exp[$];
    int   n_checks;
    int   n_errors;

    mod_n_up_counter #(.N(10), .WIDTH(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .count (count_a),
        .tc    (tc_a)
    );

    mod_n_up_counter #(.N(16), .WIDTH(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .count (count_b),
        .tc    (tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive reset for one edge on the chosen instance, then queue what must follow it.
    task automatic step(input bit dut16, input logic rst, input int exp_cnt, input int mod_n);
        exp_t e;
        @(negedge clk);
        if (dut16) reset_b = rst;
        else       reset_a = rst;
        @(posedge clk);
        #1;
        e.dut16     = dut16;
        e.exp_count = 4'(exp_cnt);
        e.exp_tc    = (exp_cnt == mod_n - 1);
        q_exp.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                if (e.dut16) begin
                    check("n16_count", int'(count_b), int'(e.exp_count));
                    check("n16_tc", int'(tc_b), int'(e.exp_tc));
                end else begin
                    check("n10_count", int'(count_a), int'(e.exp_count));
                    check("n10_tc", int'(tc_a), int'(e.exp_tc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        n_checks = 0;
        n_errors = 0;
        reset_a  = 1'b1;
        reset_b  = 1'b1;

        // Reset edge, then 12 free-running edges: 1..9,0,1,2
        step(1'b0, 1'b1, 0, 10);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, i % 10, 10);

        // Run up to 6, reset for one edge, resume
        for (int v = 3; v <= 6; v++) step(1'b0, 1'b0, v, 10);
        step(1'b0, 1'b1, 0, 10);
        step(1'b0, 1'b0, 1, 10);
        step(1'b0, 1'b0, 2, 10);

        // Held reset for 5 edges
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, 10);
        step(1'b0, 1'b0, 1, 10);
        step(1'b0, 1'b0, 2, 10);

        // Illegal state 12 with N=10 must clear on the next edge
        @(negedge clk);
        #1;
        force dut_a.r_count = 4'd12;
        #1;
        check("illegal_count", int'(count_a), 12);
        check("illegal_tc", int'(tc_a), 0);
        release dut_a.r_count;
        @(posedge clk);
        #1;
        q_exp.push_back('{dut16: 1'b0, exp_count: 4'd0, exp_tc: 1'b0});
        for (int v = 1; v <= 3; v++) step(1'b0, 1'b0, v, 10);

        // Full-range modulus: reset then 17 edges, 15 -> 0 -> 1
        step(1'b1, 1'b1, 0, 16);
        for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, i % 16, 16);

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_n_up_counter.md
Name: mod_n_up_counter

Overview:
- Free-running synchronous modulo-N up counter. Counts 0, 1, …, N-1, then wraps to 0.
- Used as a timebase / sequence-index generator. No enable and no load input.
- Single clock domain; no handshakes.

Parameters:
- N, 10, modulus (count sequence length). Legal range: 2 ≤ N ≤ 2**WIDTH.
- WIDTH, 4, width of the count output in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- count  output  WIDTH  current counter value, driven directly from a register.
- tc  output  1  terminal-count flag; high while count == N-1. Combinational decode of the count register. May be left unconnected.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- On a rising edge with reset=1: count <= 0. Reset has priority over counting.
- On a rising edge with reset=0:
  - if count == N-1, count <= 0 (wrap);
  - otherwise count <= count + 1.
- Increment width: the addition is WIDTH bits wide. Wrap is decided by comparison with N-1, never by natural overflow. With N == 2**WIDTH the compare and the overflow coincide; the result must still be 0.
- Latency: count changes exactly one edge after the condition is sampled. No combinational path from reset to count.
- tc = (count == N-1). It is 0 during and after reset until count reaches N-1.
- Reset asserted mid-sequence (any count value): count = 0 after that edge, and counting resumes on the first edge with reset=0.
- Reset held for multiple cycles: count stays 0.
- Power-up, before the first reset edge: count is X in simulation. No initial value is required.
- Illegal-state recovery: if count ≥ N (e.g. upset or X-cleared), the next non-reset edge loads 0.
- Parameter check: an elaboration-time error if N < 2, N > 2**WIDTH, or WIDTH < 1.

Decomposition:
- No shared package required. N and WIDTH are local parameters of the block.
- If the system defines a common timebase modulus, it belongs in the project constants package and is passed in as N.
- No sub-modules; a single always_ff register plus compare logic.

Test Plan:
- Reset: clk period 10, reset=1 for the first edge, then 0 → count = 0 after the reset edge; tc = 0.
- Count/wrap, N=10: free-run 12 edges after reset → count sequence 1,2,…,9,0,1,2. tc high only while count = 9.
- Mid-run reset: assert reset for one edge when count = 6 → count = 0 on that edge, then 1,2,… on following edges.
- Held reset: reset=1 for 5 edges → count stays 0 throughout. First increment to 1 on the edge after reset deasserts.
- Full-range modulus, N=16, WIDTH=4: run 17 edges → count goes 15 → 0 cleanly. tc high at 15.
- Illegal state: force count = 12 with N=10, then release → next edge count = 0. Counting is normal thereafter.
